lfsr_prng_mc: RTL



---
 rtl/lfsr_prng_mc.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lfsr_prng_mc.sv
// lfsr_prng_mc: multi-channel XNOR-LFSR pseudo-random generator.
//
// A WIDTH-bit XNOR LFSR (WIDTH = 32 or 64) free-runs for WARMUP steps after
// reset or after a reseed. It then advances one step in each cycle where any
// channel requests a value. Channel k reads lfsr[k*SIZE +: SIZE] straight from
// the register, so every channel requesting in the same cycle sees the same
// pre-advance value.
//
// Ports:
//   clk             clock
//   rst_l           asynchronous active-low reset; loads seed_i and restarts warm-up
//   seed_i          seed, bits [WIDTH-1:0] used (reset load and reseed)
//   reseed_valid_i  reseed request, held by the requester until accepted
//   reseed_ready_o  reseed can be accepted (RUN only)
//   req_i           per-channel consume request
//   rnd_o           channel outputs, channel k = rnd_o[k*SIZE +: SIZE]
//   rnd_valid_o     outputs usable (RUN)
//   lockup_o        one-cycle pulse after an all-ones lockup recovery
//
// Build option: define LFSR_PRNG_LOCKUP_EN to enable all-ones lockup recovery.
// Without it, an all-ones state is never left and lockup_o is tied low.
//
// state | meaning
// WARM  | free-running warm-up, outputs not valid, reseed not accepted
// RUN   | outputs valid, advance on any request, reseed accepted

module lfsr_prng_mc #(
    parameter int WIDTH  = 64,
    parameter int SIZE   = 3,
    parameter int NCH    = 2,
    parameter int WARMUP = 16
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [63:0]         seed_i,
    input  logic                reseed_valid_i,
    output logic                reseed_ready_o,
    input  logic [NCH-1:0]      req_i,
    output logic [NCH*SIZE-1:0] rnd_o,
    output logic                rnd_valid_o,
    output logic                lockup_o
);

    if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("lfsr_prng_mc: WIDTH must be 32 or 64");
    end
    if (NCH * SIZE > WIDTH || NCH < 1 || SIZE < 1) begin : g_bad_slices
        $error("lfsr_prng_mc: NCH*SIZE must be between 1 and WIDTH");
    end
    if (WARMUP < 1 || WARMUP > 255) begin : g_bad_warmup
        $error("lfsr_prng_mc: WARMUP must be in 1..255");
    end

    localparam logic [7:0] WARM_LOAD = 8'(WARMUP);

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             fb;
    logic             accept_reseed;
    logic             advance;
    logic             lockup_set;

    if (WIDTH == 64) begin : g_fb64
        assign fb = ~(lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]);
    end else begin : g_fb32
        assign fb = ~(lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]);
    end

    if (WIDTH < 64) begin : g_seed_hi
        logic unused_seed_hi;
        assign unused_seed_hi = ^seed_i[63:WIDTH];
    end

    assign accept_reseed = (state_q == ST_RUN) && reseed_valid_i;
    assign advance       = (state_q == ST_WARM) || (|req_i);

    // State register plus the datapath registers that share its reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_WARM;
            lfsr_q  <= seed_i[WIDTH-1:0];
            cnt_q   <= WARM_LOAD;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WARM: if (cnt_q == 8'd1) state_d = ST_RUN;
            ST_RUN:  if (reseed_valid_i) state_d = ST_WARM;
            default: state_d = ST_WARM;
        endcase
    end

    // Datapath next values. A reseed wins over a same-cycle request, whose
    // advance is dropped. The counter holds at 1 instead of wrapping; it is
    // reloaded whenever WARM is re-entered.
    always_comb begin
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        lockup_set = 1'b0;
        if (accept_reseed) begin
            lfsr_d = seed_i[WIDTH-1:0];
            cnt_d  = WARM_LOAD;
        end else begin
            if (advance) begin
`ifdef LFSR_PRNG_LOCKUP_EN
                if (&lfsr_q) begin
                    lfsr_d     = {{(WIDTH-1){1'b1}}, 1'b0};
                    lockup_set = 1'b1;
                end else begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
                end
`else
                lfsr_d = {lfsr_q[WIDTH-2:0], fb};
`endif
            end
            if (state_q == ST_WARM && cnt_q > 8'd1) begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

`ifdef LFSR_PRNG_LOCKUP_EN
    logic lockup_q;
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) lockup_q <= 1'b0;
        else        lockup_q <= lockup_set;
    end
`else
    logic unused_lockup;
    logic lockup_q;
    assign unused_lockup = lockup_set;
    assign lockup_q      = 1'b0;
`endif

    // Outputs.
    always_comb begin
        rnd_valid_o    = (state_q == ST_RUN);
        reseed_ready_o = (state_q == ST_RUN);
        lockup_o       = lockup_q;
        rnd_o          = lfsr_q[NCH*SIZE-1:0];
    end

endmodule
